// File: rtl/window_fifo_if.sv
// Handshake bundle between the input loader, window_fifo and the PE array.
// The master side produces writes and pops; the slave side is the FIFO itself.
interface window_fifo_if #(
    parameter int unsigned BITS      = 16,
    parameter int unsigned PAR_WRITE = 1,
    parameter int unsigned PAR_READ  = 1,
    parameter int unsigned INDEX     = 3
);
    logic                      clear;
    logic                      wen;
    logic [BITS*PAR_WRITE-1:0] din;
    logic                      ready_w;
    logic                      ren;
    logic [INDEX:0]            pop_cnt;
    logic [BITS*PAR_READ-1:0]  dout;
    logic                      valid_r;
    logic [INDEX:0]            count;
    logic                      ovf;
    logic                      udf;

    modport master (
        output clear, wen, din, ren, pop_cnt,
        input  ready_w, dout, valid_r, count, ovf, udf
    );

    modport slave (
        input  clear, wen, din, ren, pop_cnt,
        output ready_w, dout, valid_r, count, ovf, udf
    );
endinterface

// File: rtl/window_fifo.sv
// Circular word FIFO: PAR_WRITE words in per beat, PAR_READ-word sliding window out,
// variable-stride pops, sticky overflow/underflow flags. DEPTH need not be a power of two.
module window_fifo #(
    parameter int unsigned BITS      = 16,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned PAR_WRITE = 1,
    parameter int unsigned PAR_READ  = 1,
    parameter int unsigned INDEX     = 3
) (
    input logic         clk,
    input logic         rst,
    window_fifo_if.slave bus
);
    localparam logic [INDEX+1:0] DEPTH_W = (INDEX+2)'(DEPTH);
    localparam logic [INDEX:0]   DEPTH_C = (INDEX+1)'(DEPTH);
    localparam logic [INDEX:0]   PW_C    = (INDEX+1)'(PAR_WRITE);
    localparam logic [INDEX:0]   PR_C    = (INDEX+1)'(PAR_READ);

    logic [BITS-1:0]  mem [DEPTH];
    logic [INDEX-1:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
    logic [INDEX:0]   count, count_next, pop_n;
    logic             ovf, udf;
    logic             ready_w, valid_r, wacc, racc;

    // Operands are always < DEPTH, so one conditional subtract is an exact modulo.
    function automatic logic [INDEX-1:0] wrap(input logic [INDEX+1:0] s);
        logic [INDEX+1:0] r;
        r = (s >= DEPTH_W) ? s - DEPTH_W : s;
        return INDEX'(r);
    endfunction

    always_comb begin
        ready_w     = (DEPTH_C - count) >= PW_C;
        valid_r     = count >= PR_C;
        wacc        = bus.wen & ready_w;
        racc        = bus.ren & valid_r;
        pop_n       = (bus.pop_cnt > PR_C) ? PR_C : bus.pop_cnt;
        count_next  = count + (wacc ? PW_C : '0) - (racc ? pop_n : '0);
        wr_ptr_next = wacc ? wrap({2'b00, wr_ptr} + (INDEX+2)'(PAR_WRITE)) : wr_ptr;
        rd_ptr_next = racc ? wrap({2'b00, rd_ptr} + {1'b0, pop_n}) : rd_ptr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else if (bus.clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
            ovf    <= ovf | (bus.wen & ~ready_w);
            udf    <= udf | (bus.ren & ~valid_r);
        end
    end

    // Most-significant din slice is the oldest word and lands at wr_ptr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wacc && !bus.clear) begin
            for (int unsigned k = 0; k < PAR_WRITE; k++) begin
                mem[wrap({2'b00, wr_ptr} + (INDEX+2)'(k))] <= bus.din[(PAR_WRITE-1-k)*BITS +: BITS];
            end
        end
    end

    always_comb begin
        bus.dout = '0;
        for (int unsigned j = 0; j < PAR_READ; j++) begin
            bus.dout[j*BITS +: BITS] = mem[wrap({2'b00, rd_ptr} + (INDEX+2)'(j))];
        end
    end

    assign bus.ready_w = ready_w;
    assign bus.valid_r = valid_r;
    assign bus.count   = count;
    assign bus.ovf     = ovf;
    assign bus.udf     = udf;
endmodule

// File: tb/tb_window_fifo.sv
// Directed bench for window_fifo (DEPTH=8, PAR_WRITE=2, PAR_READ=3) with hand-computed
// windows, plus a reference queue for the wrapping stride-2 stream.
module tb_window_fifo;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    window_fifo_if #(.BITS(16), .PAR_WRITE(2), .PAR_READ(3), .INDEX(3)) bus ();

    window_fifo #(.BITS(16), .DEPTH(8), .PAR_WRITE(2), .PAR_READ(3), .INDEX(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_win(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2);
        chk({tag, "_s0"}, bus.dout[15:0], e0);
        chk({tag, "_s1"}, bus.dout[31:16], e1);
        chk({tag, "_s2"}, bus.dout[47:32], e2);
    endtask

    // One clock with the given inputs; outputs are sampled 1 ns after the edge.
    task automatic cyc(input logic w, input logic [31:0] d, input logic r,
                       input logic [3:0] p, input logic c);
        bus.wen = w; bus.din = d; bus.ren = r; bus.pop_cnt = p; bus.clear = c;
        @(posedge clk); #1;
        bus.wen = 1'b0; bus.ren = 1'b0; bus.pop_cnt = '0; bus.clear = 1'b0; bus.din = '0;
    endtask

    localparam logic [15:0] A0 = 16'h00A0, A1 = 16'h00A1, A2 = 16'h00A2, A3 = 16'h00A3;
    localparam logic [15:0] B0 = 16'h00B0, B1 = 16'h00B1, B2 = 16'h00B2, B3 = 16'h00B3;
    localparam logic [15:0] B4 = 16'h00B4, B5 = 16'h00B5, C0 = 16'h00C0, C1 = 16'h00C1;
    localparam logic [15:0] D0 = 16'h00D0, D1 = 16'h00D1, D2 = 16'h00D2, D3 = 16'h00D3;
    localparam logic [15:0] D4 = 16'h00D4, D5 = 16'h00D5, E0 = 16'h00E0, E1 = 16'h00E1;

    initial begin
        logic [15:0] q[$];
        int unsigned wi;
        int unsigned guard;
        logic        w, r;
        logic [15:0] wa, wb;

        bus.wen = 1'b0; bus.ren = 1'b0; bus.clear = 1'b0; bus.pop_cnt = '0; bus.din = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        chk("rst_dout", bus.dout, 48'h0);
        chk("rst_count", bus.count, 0);
        chk("rst_ready", bus.ready_w, 1);
        chk("rst_valid", bus.valid_r, 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_udf", bus.udf, 0);

        // Fill and order
        cyc(1, {A1, A0}, 0, 0, 0);
        cyc(1, {A3, A2}, 0, 0, 0);
        chk("fill_count", bus.count, 4);
        chk("fill_valid", bus.valid_r, 1);
        chk_win("fill_win", A1, A0, A3);
        cyc(0, 0, 1, 1, 0);
        chk("pop1_count", bus.count, 3);
        chk_win("pop1_win", A0, A3, A2);
        cyc(0, 0, 1, 1, 0);
        chk("pop1b_count", bus.count, 2);

        // Full and overflow (slots 4..7,0,1 receive B0..B5)
        cyc(1, {B0, B1}, 0, 0, 0);
        cyc(1, {B2, B3}, 0, 0, 0);
        cyc(1, {B4, B5}, 0, 0, 0);
        chk("full_count", bus.count, 8);
        chk("full_ready", bus.ready_w, 0);
        chk_win("full_win", A3, A2, B0);
        cyc(1, {C0, C1}, 0, 0, 0);
        chk("ovf_flag", bus.ovf, 1);
        chk("ovf_count", bus.count, 8);
        chk_win("ovf_win", A3, A2, B0);
        cyc(0, 0, 1, 3, 0);
        chk("pop3_count", bus.count, 5);
        chk("pop3_ready", bus.ready_w, 1);
        chk("pop3_ovf", bus.ovf, 1);
        chk_win("pop3_win", B1, B2, B3);
        cyc(0, 0, 1, 3, 0);
        chk("wrap_count", bus.count, 2);
        chk("wrap_valid", bus.valid_r, 0);
        chk_win("wrap_win", B4, B5, A3);

        // Underflow at count=2
        cyc(0, 0, 1, 1, 0);
        chk("udf_flag", bus.udf, 1);
        chk("udf_count", bus.count, 2);
        chk_win("udf_win", B4, B5, A3);

        // Simultaneous write and pop at count=6
        cyc(1, {D0, D1}, 0, 0, 0);
        cyc(1, {D2, D3}, 0, 0, 0);
        chk("sim_pre_count", bus.count, 6);
        chk("sim_pre_ready", bus.ready_w, 1);
        chk_win("sim_pre_win", B4, B5, D0);
        cyc(1, {D4, D5}, 1, 3, 0);
        chk("sim_count", bus.count, 5);
        chk_win("sim_win", D1, D2, D3);

        // pop_cnt above PAR_READ retires only PAR_READ
        cyc(0, 0, 1, 5, 0);
        chk("clamp_count", bus.count, 2);
        chk("clamp_valid", bus.valid_r, 0);
        chk_win("clamp_win", D4, D5, B4);

        // clear beats a same-cycle write and pop; memory survives
        cyc(1, {E0, E1}, 1, 1, 1);
        chk("clr_count", bus.count, 0);
        chk("clr_ovf", bus.ovf, 0);
        chk("clr_udf", bus.udf, 0);
        chk("clr_ready", bus.ready_w, 1);
        chk("clr_valid", bus.valid_r, 0);
        chk_win("clr_win", B4, B5, D0);

        // 12-word stream with stride-2 pops, crossing the pointer wrap
        wi = 0;
        guard = 0;
        while ((wi < 12 || q.size() >= 3) && guard < 100) begin
            chk("s_count", bus.count, q.size());
            chk("s_valid", bus.valid_r, q.size() >= 3);
            if (q.size() >= 3) begin
                for (int j = 0; j < 3; j++) begin
                    chk("s_win", bus.dout[j*16 +: 16], q[j]);
                end
            end
            w  = (wi < 12) && (8 - q.size() >= 2);
            r  = q.size() >= 3;
            wa = 16'h1000 + 16'(wi);
            wb = 16'h1000 + 16'(wi + 1);
            cyc(w, {wa, wb}, r, 2, 0);
            if (r) begin
                void'(q.pop_front());
                void'(q.pop_front());
            end
            if (w) begin
                q.push_back(wa);
                q.push_back(wb);
                wi += 2;
            end
            guard++;
        end
        chk("s_bound", guard < 100, 1);
        chk("s_end_count", bus.count, q.size());
        chk("s_end_ovf", bus.ovf, 0);
        chk("s_end_udf", bus.udf, 0);

        // Asynchronous reset between edges
        cyc(1, {E0, E1}, 0, 0, 0);
        cyc(0, 0, 1, 1, 0);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("arst_count", bus.count, 0);
        chk("arst_dout", bus.dout, 48'h0);
        chk("arst_ready", bus.ready_w, 1);
        chk("arst_valid", bus.valid_r, 0);
        chk("arst_udf", bus.udf, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("post_count", bus.count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
